// File: rtl/alu_acc_bank.sv
// alu_acc_bank: banked accumulator ALU with a valid/ready command port
// and a multi-cycle shift-add multiplier.
module alu_acc_bank #(
    parameter int WIDTH = 8,
    parameter int NACC  = 4,
    localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       data_src,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] reg_out,
    input  logic [WIDTH-1:0] mem_out,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  acc_sel,
    input  logic             ce_a,
    input  logic             ce_cy,
    output logic [WIDTH-1:0] alu_in,
    output logic [WIDTH-1:0] acc_v,
    output logic             flag_cy,
    output logic             flag_z,
    output logic             flag_o,
    output logic             flag_s,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   acc_q [NACC];
    logic [NACC-1:0]    cy_q;
    logic [NACC-1:0]    z_q;
    logic [NACC-1:0]    o_q;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SELW-1:0]    bank_q, bank_d;
    logic               cea_q, cea_d;
    logic               cecy_q, cecy_d;
    logic               done_q, done_d;
    logic               mul_hi;

    logic               sel_ok;
    logic [WIDTH-1:0]   rd_acc;
    logic               rd_cy;
    logic               accept;

    logic [WIDTH:0]     ea, eb, sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cy, alu_o, alu_arith;

    logic               wr_en;
    logic [SELW-1:0]    wr_bank;
    logic               wr_ce_a, wr_ce_cy;
    logic [WIDTH-1:0]   wr_acc;
    logic               wr_cy, wr_o;

    // Operand B: bit0 low selects memory, else bit1 picks reg over imm.
    assign alu_in = data_src[0] ? (data_src[1] ? reg_out : immediate)
                                : mem_out;

    assign sel_ok = (int'(acc_sel) < NACC);
    assign rd_acc = sel_ok ? acc_q[acc_sel] : '0;
    assign rd_cy  = sel_ok ? cy_q[acc_sel] : 1'b0;

    assign acc_v   = rd_acc;
    assign flag_cy = rd_cy;
    assign flag_z  = sel_ok ? z_q[acc_sel] : 1'b0;
    assign flag_o  = sel_ok ? o_q[acc_sel] : 1'b0;
    assign flag_s  = rd_acc[WIDTH-1];
    assign done    = done_q;

    assign in_ready = rst & (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;

    assign ea = {1'b0, rd_acc};
    assign eb = {1'b0, alu_in};

    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign mul_hi    = |prod_step[2*WIDTH-1:WIDTH];

    // Single-cycle ALU result and flags for the bank being addressed.
    always_comb begin
        sum       = '0;
        alu_res   = '0;
        alu_cy    = rd_cy;
        alu_o     = 1'b0;
        alu_arith = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum       = ea + eb;
                alu_res   = sum[WIDTH-1:0];
                alu_cy    = sum[WIDTH];
                alu_o     = (rd_acc[WIDTH-1] == alu_in[WIDTH-1]) &&
                            (sum[WIDTH-1] != rd_acc[WIDTH-1]);
                alu_arith = 1'b1;
            end
            OP_SUB: begin
                sum       = ea - eb;
                alu_res   = sum[WIDTH-1:0];
                alu_cy    = sum[WIDTH];
                alu_o     = (rd_acc[WIDTH-1] != alu_in[WIDTH-1]) &&
                            (sum[WIDTH-1] != rd_acc[WIDTH-1]);
                alu_arith = 1'b1;
            end
            OP_AND:  alu_res = rd_acc & alu_in;
            OP_OR:   alu_res = rd_acc | alu_in;
            OP_XOR:  alu_res = rd_acc ^ alu_in;
            OP_LOAD: alu_res = alu_in;
            OP_ADC: begin
                sum       = ea + eb + {{WIDTH{1'b0}}, rd_cy};
                alu_res   = sum[WIDTH-1:0];
                alu_cy    = sum[WIDTH];
                alu_o     = (rd_acc[WIDTH-1] == alu_in[WIDTH-1]) &&
                            (sum[WIDTH-1] != rd_acc[WIDTH-1]);
                alu_arith = 1'b1;
            end
            OP_MUL:  alu_arith = 1'b1;
        endcase
    end

    // Command FSM: immediate writes in IDLE, shift-add steps in BUSY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        bank_d   = bank_q;
        cea_d    = cea_q;
        cecy_d   = cecy_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        wr_bank  = acc_sel;
        wr_ce_a  = 1'b0;
        wr_ce_cy = 1'b0;
        wr_acc   = '0;
        wr_cy    = 1'b0;
        wr_o     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, rd_acc};
                        mplier_d = alu_in;
                        prod_d   = '0;
                        cnt_d    = '0;
                        bank_d   = acc_sel;
                        cea_d    = ce_a;
                        cecy_d   = ce_cy;
                        state_d  = S_BUSY;
                    end else begin
                        wr_en    = 1'b1;
                        wr_bank  = acc_sel;
                        wr_ce_a  = ce_a;
                        wr_ce_cy = ce_cy & alu_arith;
                        wr_acc   = alu_res;
                        wr_cy    = alu_cy;
                        wr_o     = alu_o;
                        done_d   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    wr_en    = 1'b1;
                    wr_bank  = bank_q;
                    wr_ce_a  = cea_q;
                    wr_ce_cy = cecy_q;
                    wr_acc   = prod_step[WIDTH-1:0];
                    wr_cy    = mul_hi;
                    wr_o     = mul_hi;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // FSM and multiplier registers; reset drops any multiply in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            bank_q   <= '0;
            cea_q    <= 1'b0;
            cecy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            bank_q   <= bank_d;
            cea_q    <= cea_d;
            cecy_q   <= cecy_d;
            done_q   <= done_d;
        end
    end

    // Accumulator banks: only the addressed bank takes the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
            end
            cy_q <= '0;
            z_q  <= '1;
            o_q  <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NACC; i++) begin
                if (wr_bank == SELW'(i)) begin
                    if (wr_ce_a) begin
                        acc_q[i] <= wr_acc;
                        z_q[i]   <= (wr_acc == '0);
                        o_q[i]   <= wr_o;
                    end
                    if (wr_ce_cy) begin
                        cy_q[i] <= wr_cy;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_bank.sv
// tb_alu_acc_bank: directed bench with a reference model feeding a
// scoreboard queue that is drained on each done pulse.
module tb_alu_acc_bank;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   data_src;
    logic [W-1:0] immediate;
    logic [W-1:0] reg_out;
    logic [W-1:0] mem_out;
    logic [2:0]   op;
    logic [1:0]   acc_sel;
    logic         ce_a;
    logic         ce_cy;
    logic [W-1:0] alu_in;
    logic [W-1:0] acc_v;
    logic         flag_cy;
    logic         flag_z;
    logic         flag_o;
    logic         flag_s;
    logic         done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] acc;
        logic         cy;
        logic         z;
        logic         o;
    } exp_t;

    exp_t sb_q[$];

    int   m_acc [N];
    logic m_cy  [N];
    logic m_z   [N];
    logic m_o   [N];

    alu_acc_bank #(.WIDTH(W), .NACC(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_src  (data_src),
        .immediate (immediate),
        .reg_out   (reg_out),
        .mem_out   (mem_out),
        .op        (op),
        .acc_sel   (acc_sel),
        .ce_a      (ce_a),
        .ce_cy     (ce_cy),
        .alu_in    (alu_in),
        .acc_v     (acc_v),
        .flag_cy   (flag_cy),
        .flag_z    (flag_z),
        .flag_o    (flag_o),
        .flag_s    (flag_s),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_cy[i]  = 1'b0;
            m_z[i]   = 1'b1;
            m_o[i]   = 1'b0;
        end
        sb_q.delete();
    endtask

    task automatic show_banks(input string tag);
        for (int b = 0; b < N; b++) begin
            acc_sel = 2'(b);
            #1;
            check({tag, "_acc"}, acc_v, m_acc[b]);
            check({tag, "_cy"}, flag_cy, m_cy[b]);
            check({tag, "_z"}, flag_z, m_z[b]);
            check({tag, "_o"}, flag_o, m_o[b]);
        end
    endtask

    task automatic cmd(input logic [2:0] c_op, input logic [1:0] src,
                       input logic [W-1:0] val, input logic [1:0] bank,
                       input logic cea, input logic cecy, input bit poke,
                       output int busy);
        int   a, b, r, sr;
        logic ncy, no;
        exp_t e;
        bit   got;
        @(negedge clk);
        op        = c_op;
        data_src  = src;
        acc_sel   = bank;
        ce_a      = cea;
        ce_cy     = cecy;
        immediate = val ^ 8'h3C;
        reg_out   = val ^ 8'hC3;
        mem_out   = val ^ 8'h66;
        if (src == 2'b01) immediate = val;
        else if (src == 2'b11) reg_out = val;
        else mem_out = val;
        in_valid = 1'b1;
        #1;
        check("alu_in", alu_in, val);
        check("in_ready_idle", in_ready, 1);

        a   = m_acc[bank];
        b   = int'(val);
        r   = 0;
        sr  = 0;
        ncy = m_cy[bank];
        no  = 1'b0;
        case (c_op)
            3'd0: begin
                r = a + b; ncy = (r > 255);
                sr = sgn(a) + sgn(b); no = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                r = a - b; ncy = (a < b);
                sr = sgn(a) - sgn(b); no = (sr > 127) || (sr < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            3'd6: begin
                r = a + b + (m_cy[bank] ? 1 : 0); ncy = (r > 255);
                sr = sgn(a) + sgn(b) + (m_cy[bank] ? 1 : 0);
                no = (sr > 127) || (sr < -128);
            end
            default: begin
                r = a * b; ncy = (r > 255); no = ncy;
            end
        endcase
        r = r & 255;
        if (cea) begin
            m_acc[bank] = r;
            m_z[bank]   = (r == 0);
            m_o[bank]   = no;
        end
        if (cecy && (c_op inside {3'd0, 3'd1, 3'd6, 3'd7})) m_cy[bank] = ncy;
        e.acc = 8'(m_acc[bank]);
        e.cy  = m_cy[bank];
        e.z   = m_z[bank];
        e.o   = m_o[bank];
        sb_q.push_back(e);

        busy = 0;
        got  = 1'b0;
        @(posedge clk);
        #1;
        if (poke) begin
            op        = 3'd5;
            data_src  = 2'b01;
            immediate = 8'hEE;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 0; k < 3 * W; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!in_ready) busy++;
        end
        in_valid = 1'b0;
        check("done_seen", got, 1);
        if (got && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("acc_v", acc_v, e.acc);
            check("flag_cy", flag_cy, e.cy);
            check("flag_z", flag_z, e.z);
            check("flag_o", flag_o, e.o);
            check("flag_s", flag_s, e.acc[W-1]);
        end
    endtask

    initial begin
        int busy;
        int dn;
        rst       = 1'b0;
        in_valid  = 1'b0;
        data_src  = 2'b01;
        immediate = '0;
        reg_out   = '0;
        mem_out   = '0;
        op        = 3'd0;
        acc_sel   = 2'd0;
        ce_a      = 1'b0;
        ce_cy     = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);
        show_banks("reset");

        cmd(3'd5, 2'b01, 8'h7F, 2'd0, 1'b1, 1'b1, 1'b0, busy);
        check("load_busy", busy, 0);
        cmd(3'd0, 2'b01, 8'h01, 2'd0, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd1, 2'b01, 8'h80, 2'd0, 1'b1, 1'b1, 1'b0, busy);

        cmd(3'd5, 2'b00, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd0, 2'b10, 8'h01, 2'd0, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd6, 2'b01, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, busy);

        cmd(3'd5, 2'b01, 8'h55, 2'd2, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd5, 2'b11, 8'hAA, 2'd2, 1'b0, 1'b1, 1'b0, busy);
        show_banks("banks");

        cmd(3'd1, 2'b01, 8'h01, 2'd3, 1'b1, 1'b0, 1'b0, busy);

        cmd(3'd5, 2'b01, 8'h12, 2'd1, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd7, 2'b11, 8'h34, 2'd1, 1'b1, 1'b1, 1'b1, busy);
        check("mul_busy_cycles", busy, W);
        @(negedge clk);
        check("mul_done_single", done, 0);
        check("mul_no_poke", acc_v, m_acc[1]);

        cmd(3'd4, 2'b11, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd2, 2'b01, 8'h0F, 2'd1, 1'b1, 1'b1, 1'b0, busy);
        cmd(3'd3, 2'b00, 8'hF0, 2'd1, 1'b1, 1'b1, 1'b0, busy);
        show_banks("pre_abort");

        @(negedge clk);
        acc_sel  = 2'd1;
        op       = 3'd7;
        data_src = 2'b11;
        reg_out  = 8'h02;
        ce_a     = 1'b1;
        ce_cy    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_low", in_ready, 0);
        check("abort_done_low", done, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check("abort_ready_high", in_ready, 1);
        show_banks("abort");
        dn = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
